// File: rtl/sram_bus_adapter.sv
// sram_bus_adapter: bridges a request/grant data bus to a single-port
// synchronous word SRAM. Byte addresses are translated to word indices, and
// out-of-range accesses get an error response without touching the SRAM.
// Exactly one in-order response is returned per grant. A 2-entry response
// buffer absorbs SRAM read data while the requester holds rready low.
module sram_bus_adapter #(
  parameter int unsigned DEPTH     = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // requester side
  input  logic                     req,
  output logic                     gnt,
  input  logic [31:0]              addr,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              rdata,
  output logic                     err,
  // SRAM side
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [3:0]               sram_be,
  output logic [31:0]              sram_wdata,
  input  logic [31:0]              sram_rdata
);

  localparam int AW = $clog2(DEPTH);

  // Address decode
  logic [31:0] off;
  logic        in_range;

  // Credit / pipeline state
  logic        ready;
  logic [1:0]  occ;
  logic        pend;
  logic        p_we;
  logic        p_err;
  logic        credit_ok;

  // Response path
  logic [31:0] resp_data;
  logic [32:0] resp_word;   // {err, data}
  logic [32:0] buf_mem [2];
  logic        wptr;
  logic        rptr;
  logic [32:0] head;
  logic        pop;
  logic        push;
  logic        pop_buf;

  // Byte offset from the window base; the word index is taken from bits [31:2]
  // so the sub-word address bits are simply ignored.
  assign off      = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && ({1'b0, off[31:2]} < 31'(DEPTH));

  // A grant is only given when the buffer can hold every response that could
  // still arrive: the one being formed now (pend) plus the new one.
  assign credit_ok = (occ == 2'd0) || ((occ == 2'd1) && !pend);
  assign gnt       = ready & req & credit_ok;

  // SRAM is driven combinationally in the grant cycle; out-of-range grants
  // never enable it.
  assign sram_en    = gnt & in_range;
  assign sram_we    = we;
  assign sram_addr  = off[2 +: AW];
  assign sram_be    = be;
  assign sram_wdata = wdata;

  // The SRAM output is valid exactly one cycle after the read enable, which is
  // the cycle in which the pending stage holds that access.
  assign resp_data = (p_we | p_err) ? 32'h0 : sram_rdata;
  assign resp_word = {p_err, resp_data};

  // First-word fall-through: the oldest buffered entry wins, otherwise the
  // response being formed this cycle is presented directly.
  assign rvalid = (occ != 2'd0) | pend;
  assign head   = (occ != 2'd0) ? buf_mem[rptr] : resp_word;
  assign rdata  = rvalid ? head[31:0] : 32'h0;
  assign err    = rvalid & head[32];

  // When the buffer is empty a consumed pending response bypasses it;
  // otherwise the pending response is queued behind older entries.
  assign pop     = rvalid & rready;
  assign pop_buf = pop & (occ != 2'd0);
  assign push    = pend & ~(pop & (occ == 2'd0));

  // Ready flop holds off grants for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  // Pending stage: remembers the kind of access granted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      p_we  <= 1'b0;
      p_err <= 1'b0;
    end else begin
      pend <= gnt;
      if (gnt) begin
        p_we  <= we;
        p_err <= ~in_range;
      end
    end
  end

  // Buffer pointers and occupancy; a simultaneous push and pop keeps occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (push) begin
        wptr <= ~wptr;
      end
      if (pop_buf) begin
        rptr <= ~rptr;
      end
      case ({push, pop_buf})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage; contents need no reset because occ gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wptr] <= resp_word;
    end
  end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Bench for sram_bus_adapter: directed scenarios followed by random traffic,
// all responses checked against a byte-masked memory model and an in-order
// expectation queue.
module tb_sram_bus_adapter;

  localparam int unsigned TB_DEPTH = 16384;
  localparam int unsigned B_DEPTH  = 256;
  localparam logic [31:0] B_BASE   = 32'h0000_1000;

  logic        clk;
  logic        rst_n;

  // main instance signals
  logic        req, gnt, we, rvalid, rready, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        sram_en, sram_we;
  logic [13:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata, sram_rdata;

  // second instance (non-zero base, small depth)
  logic        b_req, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_rdata;
  logic        b_sram_en, b_sram_we;
  logic [7:0]  b_sram_addr;
  logic [3:0]  b_sram_be;
  logic [31:0] b_sram_wdata;
  logic [31:0] b_sram_rdata;

  // SRAM model preload port
  logic        pl_en;
  logic [13:0] pl_idx;
  logic [31:0] pl_val;
  logic [31:0] sram_mem [TB_DEPTH];

  // reference model
  logic [31:0] ref_mem [TB_DEPTH];
  logic [32:0] exp_q [$];

  int checks;
  int failures;
  int pop_cnt;

  // sampled outputs
  logic        s_gnt, s_rvalid, s_err, s_sram_en;
  logic [31:0] s_rdata;
  logic        sb_gnt, sb_rvalid, sb_err, sb_sram_en;
  logic [31:0] sb_rdata;
  logic [7:0]  sb_sram_addr;

  logic        hold_prev;
  logic [31:0] held_data;
  logic        held_err;

  sram_bus_adapter #(.DEPTH(TB_DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_bus_adapter #(.DEPTH(B_DEPTH), .BASE_ADDR(B_BASE)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req(b_req), .gnt(b_gnt), .addr(b_addr), .we(1'b0), .be(4'hF),
    .wdata(32'h0), .rvalid(b_rvalid), .rready(1'b1), .rdata(b_rdata),
    .err(b_err), .sram_en(b_sram_en), .sram_we(b_sram_we),
    .sram_addr(b_sram_addr), .sram_be(b_sram_be),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
  );

  assign b_sram_rdata = 32'h5A5A_5A5A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: registered read, byte-masked write, output changes only on reads
  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_idx] <= pl_val;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one granted access, from byte-address arithmetic.
  function automatic logic [32:0] model_access(input logic [31:0] a, input logic w,
                                               input logic [3:0] bmask, input logic [31:0] d);
    longint unsigned la;
    longint unsigned idx;
    la = longint'(a);
    if (la < 0 || (la / 4) >= TB_DEPTH) return {1'b1, 32'h0};
    idx = la / 4;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (bmask[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, ref_mem[idx]};
  endfunction

  // One clock: sample before the rising edge, score, then move to next negedge.
  task automatic tick();
    logic [32:0] e;
    #1;
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata; s_err = err; s_sram_en = sram_en;
    sb_gnt = b_gnt; sb_rvalid = b_rvalid; sb_rdata = b_rdata; sb_err = b_err;
    sb_sram_en = b_sram_en; sb_sram_addr = b_sram_addr;
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        chk("hold_rdata", rdata, held_data);
        chk("hold_err", 32'(err), 32'(held_err));
      end
      if (rvalid && rready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("resp_without_grant", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", rdata, e[31:0]);
          chk("resp_err", 32'(err), 32'(e[32]));
        end
      end
      if (gnt) exp_q.push_back(model_access(addr, we, be, wdata));
      chk("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
      hold_prev = rvalid && !rready;
      held_data = rdata;
      held_err  = err;
    end else begin
      hold_prev = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    checks = 0; failures = 0; pop_cnt = 0; hold_prev = 1'b0;
    held_data = '0; held_err = 1'b0;
    rst_n = 1'b0; req = 1'b1; addr = 32'h0; we = 1'b0; be = 4'hF; wdata = '0;
    rready = 1'b0; b_req = 1'b0; b_addr = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    @(negedge clk);

    // Preload 64 words under reset, with req held high to prove gnt stays low.
    for (int i = 0; i < 64; i++) begin
      pl_en  = 1'b1;
      pl_idx = 14'(i);
      pl_val = (i == 5) ? 32'hDEADBEEF : (i == 3) ? 32'h11223344 : $urandom;
      ref_mem[i] = pl_val;
      tick();
    end
    pl_en = 1'b0;
    chk("reset_gnt", 32'(s_gnt), 32'd0);
    chk("reset_rvalid", 32'(s_rvalid), 32'd0);
    chk("reset_rdata", s_rdata, 32'd0);
    chk("reset_err", 32'(s_err), 32'd0);
    chk("reset_sram_en", 32'(s_sram_en), 32'd0);

    // release: first cycle has no grant
    rst_n = 1'b1;
    tick();
    chk("post_reset_no_gnt", 32'(s_gnt), 32'd0);

    // read word 5
    rready = 1'b1; addr = 32'h14; we = 1'b0; be = 4'hF;
    tick();
    chk("rd5_gnt", 32'(s_gnt), 32'd1);
    chk("rd5_sram_en", 32'(s_sram_en), 32'd1);
    req = 1'b0;
    tick();
    chk("rd5_rvalid", 32'(s_rvalid), 32'd1);
    chk("rd5_rdata", s_rdata, 32'hDEADBEEF);
    chk("rd5_err", 32'(s_err), 32'd0);

    // byte-masked write to word 3, then read back
    req = 1'b1; addr = 32'hC; we = 1'b1; be = 4'b0101; wdata = 32'hAABBCCDD;
    tick();
    chk("wr3_gnt", 32'(s_gnt), 32'd1);
    we = 1'b0; be = 4'hF;
    tick();
    chk("wr3_resp_rvalid", 32'(s_rvalid), 32'd1);
    chk("wr3_resp_rdata", s_rdata, 32'h0);
    req = 1'b0;
    tick();
    chk("rd3_rdata", s_rdata, 32'h11BB33DD);

    // out-of-range read
    req = 1'b1; addr = 32'(4 * TB_DEPTH);
    tick();
    chk("oor_gnt", 32'(s_gnt), 32'd1);
    chk("oor_sram_en", 32'(s_sram_en), 32'd0);
    req = 1'b0;
    tick();
    chk("oor_err", 32'(s_err), 32'd1);
    chk("oor_rdata", s_rdata, 32'h0);

    // non-zero base: below base is an error, base itself maps to word 0
    b_req = 1'b1; b_addr = 32'h0FFC;
    tick();
    chk("b_low_gnt", 32'(sb_gnt), 32'd1);
    chk("b_low_sram_en", 32'(sb_sram_en), 32'd0);
    b_addr = 32'h1000;
    tick();
    chk("b_low_err", 32'(sb_err), 32'd1);
    chk("b_base_sram_en", 32'(sb_sram_en), 32'd1);
    chk("b_base_sram_addr", 32'(sb_sram_addr), 32'd0);
    b_req = 1'b0;
    tick();
    chk("b_base_err", 32'(sb_err), 32'd0);
    chk("b_base_rdata", sb_rdata, 32'h5A5A5A5A);
    tick();

    // four reads with rready low: two grants, then no gaps once rready rises
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0;
    tick();
    chk("bp_gnt0", 32'(s_gnt), 32'd1);
    addr = 32'h4;
    tick();
    chk("bp_gnt1", 32'(s_gnt), 32'd1);
    addr = 32'h8;
    tick();
    chk("bp_gnt2_blocked", 32'(s_gnt), 32'd0);
    tick();
    chk("bp_gnt3_blocked", 32'(s_gnt), 32'd0);
    chk("bp_rvalid_held", 32'(s_rvalid), 32'd1);
    rready = 1'b1;
    pop_cnt = 0;
    tick();
    chk("bp_no_same_cycle_credit", 32'(s_gnt), 32'd0);
    guard = 0;
    while (pop_cnt < 4 && guard < 12) begin
      tick();
      guard++;
      chk("bp_no_gap", 32'(s_rvalid), 32'd1);
      if (s_gnt) begin
        if (addr == 32'h8) addr = 32'hC;
        else req = 1'b0;
      end
    end
    chk("bp_pop_count", 32'(pop_cnt), 32'd4);
    req = 1'b0;
    tick();

    // reset with two buffered responses and req high
    rready = 1'b0; req = 1'b1; addr = 32'h20;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("mid_rst_gnt", 32'(s_gnt), 32'd0);
    tick();
    rst_n = 1'b1; rready = 1'b1;
    tick();
    chk("rst_release_no_gnt", 32'(s_gnt), 32'd0);
    chk("rst_release_no_stale", 32'(s_rvalid), 32'd0);
    tick();
    chk("rst_resume_gnt", 32'(s_gnt), 32'd1);
    req = 1'b0;
    tick();
    chk("rst_resume_rvalid", 32'(s_rvalid), 32'd1);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      req    = ($urandom % 4) != 0;
      rready = ($urandom % 3) != 0;
      we     = $urandom % 2;
      be     = 4'($urandom);
      wdata  = $urandom;
      if ($urandom % 8 == 0)
        addr = ($urandom % 2) ? 32'(4 * TB_DEPTH) + ($urandom % 4096) : 32'hFFFF_FFF0;
      else
        addr = ($urandom % 64) * 4 + ($urandom % 4);
      tick();
    end

    // drain
    req = 1'b0; rready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      tick();
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("idle_rvalid", 32'(s_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
